// File: rtl/lsu_mem_adapter.sv
// rtl/lsu_mem_adapter.sv - load/store adapter from core funct3 requests to a word-wide memory
// Optional: define IMEM_WRITE_PROTECT_EN to fault stores below DATA_BASE.
module lsu_mem_adapter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h00001000,
  parameter logic [31:0] DATA_BASE  = 32'h00000800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_we
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  lane_q;      // byte offset within the word
  logic [2:0]  funct3_q;
  logic [15:0] wdata_lo_q;  // only the low halfword feeds a sub-word merge

  logic        f3_legal;
  logic        misaligned;
  logic        out_of_range;
  logic        prot_err;
  logic        req_err;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic [31:0] merged;

`ifdef IMEM_WRITE_PROTECT_EN
  assign prot_err = req_we && (req_addr < DATA_BASE);
`else
  assign prot_err = 1'b0;
`endif

  // Classify the incoming request; any fault skips the memory entirely.
  always_comb begin
    f3_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !req_we;
      default:                f3_legal = 1'b0;
    endcase
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr >= ADDR_LIMIT);
    req_err      = !f3_legal || misaligned || out_of_range || prot_err;
  end

  // Lane extraction and extension for loads; word loads use a zero shift.
  always_comb begin
    shifted = mem_data_out >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h000000, shifted[7:0]};
      3'b101:  load_ext = {16'h0000, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Read-modify-write: splice the store byte/halfword into the current word.
  always_comb begin
    merged = mem_data_out;
    if (funct3_q[0]) begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_lo_q;
    end else begin
      merged[{lane_q, 3'b000} +: 8] = wdata_lo_q[7:0];
    end
  end

  // Write strobe is gated by reset so a reset during WRITE never commits.
  assign mem_we = (state == WRITE) && !reset;

  // Main FSM; all outputs except mem_we are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'h0;
      resp_err    <= 1'b0;
      mem_address <= 32'h0;
      mem_data_in <= 32'h0;
      lane_q      <= 2'b00;
      funct3_q    <= 3'b000;
      wdata_lo_q  <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lane_q     <= req_addr[1:0];
            funct3_q   <= req_funct3;
            wdata_lo_q <= req_wdata[15:0];
            req_ready  <= 1'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (!req_we) begin
              state       <= LOAD;
              mem_address <= req_addr;
            end else if (req_funct3 == 3'b010) begin
              state       <= WRITE;
              mem_address <= req_addr;
              mem_data_in <= req_wdata;
            end else begin
              state       <= MERGE;
              mem_address <= req_addr;
            end
          end
        end
        LOAD: begin
          resp_rdata  <= load_ext;
          resp_err    <= 1'b0;
          resp_valid  <= 1'b1;
          mem_address <= 32'h0;
          state       <= RESP;
        end
        MERGE: begin
          mem_data_in <= merged;
          state       <= WRITE;
        end
        WRITE: begin
          mem_address <= 32'h0;
          mem_data_in <= 32'h0;
          resp_rdata  <= 32'h0;
          resp_err    <= 1'b0;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_adapter.md
Name: lsu_mem_adapter

Overview:
- Load/store unit that sits directly upstream of the word-wide unified memory.
- Converts core load/store requests (RISC-V funct3 encoding) into the memory's interface: 32-bit address, word index taken from address[13:2], combinational read, one-cycle registered write enable.
- Byte and halfword loads: lane extraction plus sign or zero extension.
- Byte and halfword stores: read-modify-write, because the memory has only word writes.
- Detects misaligned, illegal-funct3 and out-of-range accesses.

Parameters:
- ADDR_LIMIT, 32'h00001000: first invalid byte address. Any access with addr >= ADDR_LIMIT is an error.
- DATA_BASE, 32'h00000800: start of the data region. Used only by the optional feature.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous reset, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  adapter can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V load/store funct3.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access faulted; qualified by resp_valid.
- mem_address  out  32  to memory address; 0 when idle.
- mem_data_in  out  32  to memory write data; 0 when not writing.
- mem_data_out  in  32  from memory; combinational read of mem_address.
- mem_we  out  1  to memory write enable.

Behaviour:
- Reset: all outputs 0 except req_ready = 1; state = IDLE; latched request registers cleared.
- Gating: mem_we = (state == WRITE) && !reset. No write is issued in any cycle where reset is high.
- Accept: a request is taken on a rising edge with req_valid && req_ready. req_addr, req_we, req_funct3 and req_wdata are latched. The core may change its inputs afterwards.
- Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal store funct3: 000 SB, 001 SH, 010 SW. Any other code is an error.
- Alignment: halfword requires addr[0] = 0; word requires addr[1:0] = 0. A violation is an error.
- Range: addr >= ADDR_LIMIT is an error.
- Error handling: no memory access; next state is RESP with resp_err = 1 and resp_rdata = 0.
- State IDLE: req_ready = 1. On accept, go to:
  - RESP on error;
  - LOAD for any load;
  - WRITE for SW;
  - MERGE for SB/SH.
- State LOAD: mem_address = latched addr. Capture the selected lane of mem_data_out:
  - byte lane = addr[1:0]; halfword lane = addr[1];
  - sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Next state RESP.
- State MERGE: mem_address = addr. Merged word = mem_data_out with the addressed byte or halfword replaced by req_wdata[7:0] or [15:0]. Next state WRITE.
- State WRITE: mem_address = addr; mem_data_in = merged word (SB/SH) or wdata (SW); mem_we = 1 for exactly this cycle. Next state RESP.
- State RESP: resp_valid = 1 for one cycle; resp_rdata and resp_err driven. Next state IDLE.
- Latency (N = accept edge):
  - error: response cycle N+1;
  - load / SW: N+2;
  - SB/SH: N+3.
- Throughput: next accept is possible on the edge ending RESP+1 (IDLE), i.e. no back-to-back overlap.
- The memory write commits on the clock edge at the end of WRITE. A load issued immediately after sees the new data.
- Reset mid-operation: any state returns to IDLE at the next edge. No write is performed if reset is high during WRITE. The pending request is dropped with no response.
- resp_valid is a pulse with no backpressure; the consumer must sample it.

Optional Feature:
- IMEM_WRITE_PROTECT_EN
- Defined: any store with addr < DATA_BASE is an error (resp_err = 1, no MERGE/WRITE, response at N+1). Loads of that region are unaffected.
- Undefined: stores anywhere below ADDR_LIMIT are legal; no DATA_BASE logic is generated.

Test Plan:
- Preload word 0x800 = 0x8899AABB.
  - LB 0x801 -> resp_rdata 0xFFFFFFAA, resp_err 0, resp_valid at N+2.
  - LBU 0x801 -> 0x000000AA.
- LH 0x802 -> 0xFFFF8899; LHU 0x802 -> 0x00008899; LW 0x800 -> 0x8899AABB. Each completes at N+2 with mem_we never high.
- SB 0x803, wdata 0x12345677:
  - mem_we high exactly one cycle at N+2, resp at N+3;
  - subsequent LW 0x800 -> 0x7799AABB.
- Error cases, each with resp_err 1 at N+1, resp_rdata 0, no mem_we, memory unchanged:
  - LW 0x806 (misaligned);
  - SH 0x801 (misaligned);
  - SW 0x1000 (range);
  - funct3 011 (illegal).
- SH 0x802, wdata 0xCAFE with reset asserted during WRITE -> mem_we stays 0, no resp_valid, req_ready = 1 after reset release, LW 0x800 unchanged.
- SW 0x100, data 0xDEADBEEF:
  - with IMEM_WRITE_PROTECT_EN -> resp_err 1 at N+1, word at 0x100 unchanged;
  - without -> write at N+1, resp_err 0 at N+2, LW 0x100 -> 0xDEADBEEF.
